// File: rtl/avst_arb_pkg.sv
// Shared types for the 2:1 Avalon-ST packet arbiter: FSM state, beat layout, default widths.
// No logic of its own; latency and backpressure are defined by the modules importing it.
package avst_arb_pkg;

  localparam int DATA_W_DEF     = 24;
  localparam int EMPTY_W_DEF    = 2;
  localparam int LEVEL_W_DEF    = 12;
  localparam int FIFO_DEPTH_DEF = 2048;
  localparam int MIN_SPACE_DEF  = 64;

  // Encoding doubles as the one-hot grant output.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [EMPTY_W_DEF-1:0] empty;
    logic [DATA_W_DEF-1:0]  data;
  } beat_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/avst_pipe_reg.sv
// One-stage valid/ready output register carrying a whole beat.
// Latency 1 cycle, full throughput; upstream ready = out_ready | ~out_valid.
module avst_pipe_reg
  import avst_arb_pkg::*;
#(
  parameter type T = beat_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_beat,
  output logic out_valid,
  input  logic out_ready,
  output T     out_beat
);

  assign in_ready = out_ready | ~out_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_beat <= in_beat;
      end
    end
  end

endmodule

// File: rtl/avst_packet_arbiter_2to1.sv
// Packet-level round-robin 2:1 arbiter in front of the video FIFO; drops orphan beats.
// Latency 1 cycle plus 1-cycle grant bubble; stalls only on out_ready once a packet starts.
module avst_packet_arbiter_2to1
  import avst_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int EMPTY_W    = EMPTY_W_DEF,
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int MIN_SPACE  = MIN_SPACE_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic [EMPTY_W-1:0] in0_empty,
  input  logic               in0_sop,
  input  logic               in0_eop,
  input  logic               in0_valid,
  output logic               in0_ready,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               in1_sop,
  input  logic               in1_eop,
  input  logic               in1_valid,
  output logic               in1_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic [1:0]         grant,
  output logic [15:0]        drop_count
);

  localparam int LVL_W1 = LEVEL_W + 1;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } lane_beat_t;

  arb_state_t  state;
  logic        last_grant;
  logic        req0, req1, space_ok;
  logic        drop0, drop1;
  logic        pipe_in_valid, pipe_in_ready;
  logic [LVL_W1-1:0] level_need;
  lane_beat_t  in0_beat, in1_beat, pipe_in_beat, pipe_out_beat;

  assign req0 = in0_valid & in0_sop;
  assign req1 = in1_valid & in1_sop;

  // One extra bit so a near-full level plus the margin cannot wrap into "space available".
  assign level_need = {1'b0, fifo_level} + LVL_W1'(MIN_SPACE);
  assign space_ok   = (level_need <= LVL_W1'(FIFO_DEPTH));

  assign drop0 = (state != LOCK0) & in0_valid & ~in0_sop;
  assign drop1 = (state != LOCK1) & in1_valid & ~in1_sop;

  assign in0_ready = reset_n & ((state == LOCK0) ? pipe_in_ready : drop0);
  assign in1_ready = reset_n & ((state == LOCK1) ? pipe_in_ready : drop1);

  assign in0_beat = '{sop: in0_sop, eop: in0_eop, empty: in0_empty, data: in0_data};
  assign in1_beat = '{sop: in1_sop, eop: in1_eop, empty: in1_empty, data: in1_data};

  assign pipe_in_valid = ((state == LOCK0) & in0_valid) | ((state == LOCK1) & in1_valid);
  assign pipe_in_beat  = (state == LOCK1) ? in1_beat : in0_beat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (space_ok) begin
            if (req0 && (!req1 || last_grant)) begin
              state      <= LOCK0;
              last_grant <= 1'b0;
            end else if (req1) begin
              state      <= LOCK1;
              last_grant <= 1'b1;
            end
          end
        end
        LOCK0: if (in0_valid && pipe_in_ready && in0_eop) state <= IDLE;
        LOCK1: if (in1_valid && pipe_in_ready && in1_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 16'd0;
    end else begin
      drop_count <= sat_add16(drop_count, {1'b0, drop0} + {1'b0, drop1});
    end
  end

  assign grant = state;

  avst_pipe_reg #(
    .T(lane_beat_t)
  ) u_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (pipe_in_valid),
    .in_ready  (pipe_in_ready),
    .in_beat   (pipe_in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_beat  (pipe_out_beat)
  );

  assign out_data  = pipe_out_beat.data;
  assign out_empty = pipe_out_beat.empty;
  assign out_sop   = pipe_out_beat.sop;
  assign out_eop   = pipe_out_beat.eop;

endmodule
